// File: rtl/i2c_master_byte.sv
// Single-byte I2C master bit engine driven by divider SCL-phase strobes.
// Optional `I2C_ARB_LOST_EN adds the arb_lost output and SDA readback check.
module i2c_master_byte #(
   parameter bit READ_ACK = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_p,
   input  logic       scl_n,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] wdata,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
`ifdef I2C_ARB_LOST_EN
   output logic       arb_lost,
`endif
   output logic [7:0] rdata
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA,
      WACK, RDATA, RNACK, STOP
   } state_t;

   state_t     state;
   logic [7:0] ash;
   logic [7:0] wsh;
   logic [7:0] rsh;
   logic [2:0] cnt;
   logic       smp;
   logic       ph;
   logic       clk_en;

   // START ignores strobes until its first scl_p
   assign clk_en = (state != IDLE) && !(state == START && !ph);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sda_oe  <= 1'b0;
         scl_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rdata   <= 8'h00;
         ash     <= 8'h00;
         wsh     <= 8'h00;
         rsh     <= 8'h00;
         cnt     <= 3'd0;
         smp     <= 1'b0;
         ph      <= 1'b0;
`ifdef I2C_ARB_LOST_EN
         arb_lost <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef I2C_ARB_LOST_EN
         arb_lost <= 1'b0;
`endif
         if (clk_en) begin
            if (scl_n)
               scl_oe <= 1'b1;
            else if (scl_p)
               scl_oe <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  ash     <= {addr, rw};
                  wsh     <= wdata;
                  busy    <= 1'b1;
                  ack_err <= 1'b0;
                  ph      <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (scl_n && ph) begin
                  sda_oe <= ~ash[7];
                  cnt    <= 3'd7;
                  state  <= ADDR;
               end else if (scl_p && !scl_n) begin
                  sda_oe <= 1'b1;
                  ph     <= 1'b1;
               end
            end
            ADDR, WDATA: begin
               if (scl_n) begin
                  if (cnt == 3'd0) begin
                     sda_oe <= 1'b0;
                     state  <= (state == ADDR) ? ADDR_ACK : WACK;
                  end else begin
                     cnt    <= cnt - 3'd1;
                     sda_oe <= (state == ADDR) ? ~ash[cnt - 3'd1]
                                               : ~wsh[cnt - 3'd1];
                  end
               end
`ifdef I2C_ARB_LOST_EN
               else if (scl_p && !sda_oe && !sda_in) begin
                  arb_lost <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
`endif
            end
            ADDR_ACK: begin
               if (scl_n) begin
                  cnt <= 3'd7;
                  if (smp) begin
                     ack_err <= 1'b1;
                     sda_oe  <= 1'b1;
                     ph      <= 1'b0;
                     state   <= STOP;
                  end else if (!ash[0]) begin
                     sda_oe <= ~wsh[7];
                     state  <= WDATA;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= RDATA;
                  end
               end else if (scl_p) begin
                  smp <= sda_in;
               end
            end
            WACK: begin
               if (scl_n) begin
                  ack_err <= smp;
                  sda_oe  <= 1'b1;
                  ph      <= 1'b0;
                  state   <= STOP;
               end else if (scl_p) begin
                  smp <= sda_in;
               end
            end
            RDATA: begin
               if (scl_n) begin
                  if (cnt == 3'd0) begin
                     sda_oe <= READ_ACK;
                     state  <= RNACK;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end else if (scl_p) begin
                  rsh <= {rsh[6:0], sda_in};
               end
            end
            RNACK: begin
               if (scl_n) begin
                  sda_oe <= 1'b1;
                  ph     <= 1'b0;
                  state  <= STOP;
               end
            end
            STOP: begin
               if (scl_n && ph) begin
                  scl_oe <= 1'b0;
                  sda_oe <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  if (ash[0])
                     rdata <= rsh;
                  state  <= IDLE;
               end else if (scl_p && !scl_n) begin
                  ph <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a bit-level slave model.
// Covers write, address NACK, read, busy start, async reset, arbitration.
module tb_i2c_master_byte;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_p = 1'b0;
   logic       scl_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] addr = 7'h00;
   logic       rw = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       sda_in;
   logic       sda_oe, scl_oe, busy, done, ack_err;
   logic [7:0] rdata;
`ifdef I2C_ARB_LOST_EN
   logic       arb_lost;
`endif

   i2c_master_byte #(.READ_ACK(1'b0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl_p   (scl_p),
      .scl_n   (scl_n),
      .start   (start),
      .addr    (addr),
      .rw      (rw),
      .wdata   (wdata),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .scl_oe  (scl_oe),
      .busy    (busy),
      .done    (done),
      .ack_err (ack_err),
`ifdef I2C_ARB_LOST_EN
      .arb_lost(arb_lost),
`endif
      .rdata   (rdata)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nbad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // divider model: scl_p and scl_n each once per 8 clocks
   initial begin
      int sph = 0;
      forever begin
         @(negedge clk);
         scl_p = (sph == 2);
         scl_n = (sph == 6);
         sph = (sph + 1) % 8;
      end
   end

   logic       slave_pull = 1'b0;
   logic       clr = 1'b0;
   logic       t_rw = 1'b0, t_na = 1'b0, t_nd = 1'b0, t_arb = 1'b0;
   logic [7:0] t_rb = 8'h00;
   int         nrise, nfall, ndone, nstart, nstop, narb;
   logic       bits [0:31];
   logic       busy_at_done;
   logic       pscl = 1'b0, psda = 1'b0;

   assign sda_in = ~(sda_oe | slave_pull);

   function automatic logic pull_for(int s);
      if (s == 1 && t_arb) return 1'b1;
      if (s == 9) return !t_na;
      if (s >= 10 && s <= 17 && t_rw) return ~t_rb[17 - s];
      if (s == 18 && !t_rw) return !t_nd;
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (clr) begin
         nrise = 0; nfall = 0; ndone = 0;
         nstart = 0; nstop = 0; narb = 0;
         slave_pull = 1'b0;
      end else begin
         if (pscl && !scl_oe) begin
            if (nrise < 32) bits[nrise] = sda_in;
            nrise++;
         end
         if (!pscl && scl_oe) begin
            nfall++;
            slave_pull = pull_for(nfall);
         end
         if (!pscl && !scl_oe && psda != sda_oe) begin
            if (sda_oe) nstart++;
            else nstop++;
         end
         if (done) begin
            ndone++;
            busy_at_done = busy;
         end
`ifdef I2C_ARB_LOST_EN
         if (arb_lost) narb++;
`endif
      end
      pscl = scl_oe;
      psda = sda_oe;
   end

   function automatic logic [7:0] byte_at(int o);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7 - i] = bits[o + i];
      return b;
   endfunction

   task automatic launch(input logic [6:0] a, input logic r,
                         input logic [7:0] d, input logic [7:0] rb,
                         input logic na, input logic nd,
                         input logic arb);
      t_rw = r; t_na = na; t_nd = nd; t_rb = rb; t_arb = arb;
      @(posedge clk); clr = 1'b1;
      @(posedge clk); clr = 1'b0;
      @(negedge clk);
      addr = a; rw = r; wdata = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input bit inject);
      bit seen = 0;
      bit injected = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (ndone > 0 || narb > 0) seen = 1;
         if (inject && !injected && nrise >= 12) begin
            addr = 7'h11; wdata = 8'hFF; rw = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            injected = 1;
         end
      end
      chk({tag, "_end"}, 32'(seen), 32'd1);
      repeat (150) @(negedge clk);
   endtask

   task automatic chk_write(input string tag, input logic [7:0] ab,
                            input logic [7:0] db);
      chk({tag, "_addr"}, 32'(byte_at(0)), 32'(ab));
      chk({tag, "_ack9"}, 32'(bits[8]), 32'd0);
      chk({tag, "_data"}, 32'(byte_at(9)), 32'(db));
      chk({tag, "_ack18"}, 32'(bits[17]), 32'd0);
      chk({tag, "_rises"}, 32'(nrise), 32'd19);
      chk({tag, "_start"}, 32'(nstart), 32'd1);
      chk({tag, "_stop"}, 32'(nstop), 32'd1);
      chk({tag, "_done"}, 32'(ndone), 32'd1);
      chk({tag, "_bsydn"}, 32'(busy_at_done), 32'd0);
      chk({tag, "_ackerr"}, 32'(ack_err), 32'd0);
      chk({tag, "_lines"}, 32'({sda_oe, scl_oe, busy}), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sda", 32'(sda_oe), 32'd0);
      chk("rst_scl", 32'(scl_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ackerr", 32'(ack_err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      launch(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_end("wr", 1'b0);
      chk_write("wr", 8'hA0, 8'hA5);

      launch(7'h27, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
      wait_end("nack", 1'b0);
      chk("nack_addr", 32'(byte_at(0)), 32'h4E);
      chk("nack_ack9", 32'(bits[8]), 32'd1);
      chk("nack_rises", 32'(nrise), 32'd10);
      chk("nack_ackerr", 32'(ack_err), 32'd1);
      chk("nack_done", 32'(ndone), 32'd1);
      chk("nack_stop", 32'(nstop), 32'd1);

      launch(7'h3C, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
      wait_end("rd", 1'b0);
      chk("rd_addr", 32'(byte_at(0)), 32'h79);
      chk("rd_ack9", 32'(bits[8]), 32'd0);
      chk("rd_bits", 32'(byte_at(9)), 32'h5A);
      chk("rd_slot18", 32'(bits[17]), 32'd1);
      chk("rd_rdata", 32'(rdata), 32'h5A);
      chk("rd_ackerr", 32'(ack_err), 32'd0);
      chk("rd_rises", 32'(nrise), 32'd19);
      chk("rd_stop", 32'(nstop), 32'd1);
      chk("rd_done", 32'(ndone), 32'd1);

      launch(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_end("bsy", 1'b1);
      chk_write("bsy", 8'hA0, 8'hA5);
      chk("bsy_rdata_kept", 32'(rdata), 32'h5A);

      launch(7'h3C, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000 && nrise < 12; i++) @(negedge clk);
      chk("arst_reach", 32'(nrise >= 12), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_sda", 32'(sda_oe), 32'd0);
      chk("arst_scl", 32'(scl_oe), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      launch(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_end("post", 1'b0);
      chk_write("post", 8'hA0, 8'hA5);
      chk("post_rdata", 32'(rdata), 32'd0);

`ifdef I2C_ARB_LOST_EN
      launch(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
      wait_end("arb", 1'b0);
      chk("arb_pulse", 32'(narb), 32'd1);
      chk("arb_done", 32'(ndone), 32'd0);
      chk("arb_stop", 32'(nstop), 32'd0);
      chk("arb_lines", 32'({sda_oe, scl_oe}), 32'd0);
      chk("arb_busy", 32'(busy), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
